// File: rtl/warp_regfile_if.sv
// warp_regfile_if: issue, writeback and re-init signal bundle for warp_regfile.
interface warp_regfile_if #(
    parameter int NUM_WARPS = 4,
    parameter int LANES     = 4,
    parameter int LANE_W    = 16
);
    localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DATA_W = LANES * LANE_W;
    logic              init_req;
    logic              init_busy;
    logic              init_done;
    logic [WID_W-1:0]  rd_warp;
    logic [3:0]        rs1_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [3:0]        rs2_addr;
    logic [DATA_W-1:0] rs2_data;
    logic              we;
    logic [WID_W-1:0]  wr_warp;
    logic [3:0]        rd_addr;
    logic [LANES-1:0]  wr_lane_mask;
    logic [DATA_W-1:0] rd_data;
    logic              sb_set;
    logic [3:0]        sb_rd;
    logic              hazard;
    modport master (
        output init_req, rd_warp, rs1_addr, rs2_addr, we, wr_warp, rd_addr,
               wr_lane_mask, rd_data, sb_set, sb_rd,
        input  init_busy, init_done, rs1_data, rs2_data, hazard
    );
    modport slave (
        input  init_req, rd_warp, rs1_addr, rs2_addr, we, wr_warp, rd_addr,
               wr_lane_mask, rd_data, sb_set, sb_rd,
        output init_busy, init_done, rs1_data, rs2_data, hazard
    );
endinterface

// File: rtl/warp_regfile.sv
// warp_regfile: multi-warp SIMD register file with a pending-write scoreboard
// and a soft re-init sweep that restores launch state without a reset.
module warp_regfile #(
    parameter int NUM_WARPS        = 4,
    parameter int LANES            = 4,
    parameter int LANE_W           = 16,
    parameter int CORE_THREAD_BASE = 0,
    parameter bit BYPASS           = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    warp_regfile_if.slave bus
);
    localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DATA_W = LANES * LANE_W;
    localparam logic [WID_W:0]   NW     = (WID_W+1)'(NUM_WARPS);
    localparam logic [WID_W-1:0] LAST_W = WID_W'(NUM_WARPS - 1);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t            state;
    logic              done;
    logic [WID_W-1:0]  sw_warp;
    logic [3:0]        sw_reg;
    logic [DATA_W-1:0] mem [NUM_WARPS][16];
    logic [15:0]       pend [NUM_WARPS];
    logic              rd_ok, wr_ok, wr_hit, set_ok;
    logic [3:0]        ra [2];
    logic [DATA_W-1:0] rv [2];

    // Launch value: r14 carries each lane's thread id, everything else is zero.
    function automatic logic [DATA_W-1:0] launch(input int w, input int r);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++)
            if (r == 14) v[l*LANE_W +: LANE_W] = LANE_W'(CORE_THREAD_BASE + w*LANES + l);
        return v;
    endfunction

    assign rd_ok  = {1'b0, bus.rd_warp} < NW;
    assign wr_ok  = bus.we && state == IDLE && {1'b0, bus.wr_warp} < NW;
    assign wr_hit = wr_ok && bus.rd_addr != 4'd15;
    assign set_ok = bus.sb_set && state == IDLE && rd_ok && bus.sb_rd != 4'd15;
    assign ra[0]  = bus.rs1_addr;
    assign ra[1]  = bus.rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rv[p] = '0;
            if (rd_ok && ra[p] != 4'd15) begin
                rv[p] = mem[bus.rd_warp][ra[p]];
                for (int l = 0; l < LANES; l++)
                    if (BYPASS && wr_hit && bus.wr_warp == bus.rd_warp && bus.rd_addr == ra[p] && bus.wr_lane_mask[l])
                        rv[p][l*LANE_W +: LANE_W] = bus.rd_data[l*LANE_W +: LANE_W];
            end
        end
    end

    assign bus.rs1_data  = rv[0];
    assign bus.rs2_data  = rv[1];
    assign bus.init_busy = state == SWEEP;
    assign bus.init_done = done;
    assign bus.hazard    = rd_ok && state == IDLE &&
        (pend[bus.rd_warp][bus.rs1_addr] || pend[bus.rd_warp][bus.rs2_addr] ||
         (bus.sb_set && pend[bus.rd_warp][bus.sb_rd]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            sw_warp <= '0;
            sw_reg  <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pend[w] <= '0;
                for (int r = 0; r < 16; r++) mem[w][r] <= launch(w, r);
            end
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                for (int l = 0; l < LANES; l++)
                    if (wr_hit && bus.wr_lane_mask[l])
                        mem[bus.wr_warp][bus.rd_addr][l*LANE_W +: LANE_W] <= bus.rd_data[l*LANE_W +: LANE_W];
                // set is issued after clear so a same-entry set wins
                if (wr_ok) pend[bus.wr_warp][bus.rd_addr] <= 1'b0;
                if (set_ok) pend[bus.rd_warp][bus.sb_rd] <= 1'b1;
                if (bus.init_req) begin
                    state   <= SWEEP;
                    sw_warp <= '0;
                    sw_reg  <= '0;
                end
            end else begin
                mem[sw_warp][sw_reg]  <= launch(int'(sw_warp), int'(sw_reg));
                pend[sw_warp][sw_reg] <= 1'b0;
                sw_reg <= sw_reg + 4'd1;
                if (sw_reg == 4'd15) begin
                    sw_warp <= sw_warp + 1'b1;
                    if (sw_warp == LAST_W) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_warp_regfile.sv
// tb_warp_regfile: bypass and non-bypass instances checked every cycle against
// a lane-level model, plus hand-computed directed expectations.
module tb_warp_regfile;
    logic clk;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    warp_regfile_if #(.NUM_WARPS(4), .LANES(4), .LANE_W(16)) b ();
    warp_regfile_if #(.NUM_WARPS(4), .LANES(4), .LANE_W(16)) b0 ();

    warp_regfile #(.BYPASS(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    warp_regfile #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    assign b0.init_req     = b.init_req;
    assign b0.rd_warp      = b.rd_warp;
    assign b0.rs1_addr     = b.rs1_addr;
    assign b0.rs2_addr     = b.rs2_addr;
    assign b0.we           = b.we;
    assign b0.wr_warp      = b.wr_warp;
    assign b0.rd_addr      = b.rd_addr;
    assign b0.wr_lane_mask = b.wr_lane_mask;
    assign b0.rd_data      = b.rd_data;
    assign b0.sb_set       = b.sb_set;
    assign b0.sb_rd        = b.sb_rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: per-lane values, pending flags, sweep position
    logic [15:0] m_reg [4][16][4];
    bit          m_pend [4][16];
    bit          m_busy, m_done;
    int          m_k;

    task automatic m_restore(input int w, input int r);
        for (int l = 0; l < 4; l++) m_reg[w][r][l] = (r == 14) ? 16'(w*4 + l) : 16'h0;
        m_pend[w][r] = 1'b0;
    endtask

    task automatic m_reset();
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 16; r++) m_restore(w, r);
        m_busy = 1'b0;
        m_done = 1'b0;
        m_k = 0;
    endtask

    task automatic m_step();
        m_done = 1'b0;
        if (m_busy) begin
            m_restore(m_k / 16, m_k % 16);
            m_k++;
            if (m_k == 64) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (b.we && b.rd_addr != 4'd15)
                for (int l = 0; l < 4; l++)
                    if (b.wr_lane_mask[l]) m_reg[b.wr_warp][b.rd_addr][l] = b.rd_data[l*16 +: 16];
            if (b.we) m_pend[b.wr_warp][b.rd_addr] = 1'b0;
            if (b.sb_set && b.sb_rd != 4'd15) m_pend[b.rd_warp][b.sb_rd] = 1'b1;
            if (b.init_req) begin
                m_busy = 1'b1;
                m_k = 0;
            end
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [3:0] a, input bit byp);
        logic [63:0] v;
        v = '0;
        if (a != 4'd15)
            for (int l = 0; l < 4; l++) begin
                v[l*16 +: 16] = m_reg[b.rd_warp][a][l];
                if (byp && b.we && !m_busy && b.wr_warp == b.rd_warp && b.rd_addr == a && b.wr_lane_mask[l])
                    v[l*16 +: 16] = b.rd_data[l*16 +: 16];
            end
        return v;
    endfunction

    function automatic logic exp_hz();
        return !m_busy && (m_pend[b.rd_warp][b.rs1_addr] || m_pend[b.rd_warp][b.rs2_addr] ||
                           (b.sb_set && m_pend[b.rd_warp][b.sb_rd]));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("rs1_byp", b.rs1_data, exp_rd(b.rs1_addr, 1'b1));
        chk("rs2_byp", b.rs2_data, exp_rd(b.rs2_addr, 1'b1));
        chk("rs1_nobyp", b0.rs1_data, exp_rd(b.rs1_addr, 1'b0));
        chk("rs2_nobyp", b0.rs2_data, exp_rd(b.rs2_addr, 1'b0));
        chk("hazard", 64'(b.hazard), 64'(exp_hz()));
        chk("hazard_nobyp", 64'(b0.hazard), 64'(exp_hz()));
        chk("busy", 64'(b.init_busy), 64'(m_busy));
        chk("done", 64'(b.init_done), 64'(m_done));
        chk("busy_nobyp", 64'(b0.init_busy), 64'(m_busy));
        chk("done_nobyp", 64'(b0.init_done), 64'(m_done));
    end

    task automatic idle_in();
        b.init_req = 0; b.rd_warp = 0; b.rs1_addr = 0; b.rs2_addr = 0;
        b.we = 0; b.wr_warp = 0; b.rd_addr = 0; b.wr_lane_mask = 0; b.rd_data = 0;
        b.sb_set = 0; b.sb_rd = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic wr(input logic [1:0] w, input logic [3:0] r, input logic [3:0] m, input logic [63:0] d);
        b.we = 1; b.wr_warp = w; b.rd_addr = r; b.wr_lane_mask = m; b.rd_data = d;
    endtask

    // cycle 0 raises init_req; a second request at 10 and a write/set at 30 probe the sweep
    task automatic run_sweep(input int rst_at, output int nbusy, output int ndone, output int last_busy, output int first_done);
        nbusy = 0; ndone = 0; last_busy = -1; first_done = -1;
        for (int i = 0; i < 90; i++) begin
            next();
            b.init_req = (i == 0 || i == 10);
            if (i == 30) begin
                wr(2'd0, 4'd0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
                b.sb_set = 1; b.sb_rd = 4'd2;
            end
            if (rst_at >= 0 && i == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
            @(negedge clk);
            if (b.init_busy) begin
                nbusy++;
                last_busy = i;
            end
            if (b.init_done) begin
                ndone++;
                if (first_done < 0) first_done = i;
            end
        end
    endtask

    int nb, nd, lb, fd;

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        next(); b.rs1_addr = 14; b.rs2_addr = 13;
        @(negedge clk);
        chk("r14_w0_reset", b.rs1_data, 64'h0003_0002_0001_0000);
        chk("r13_w0_reset", b.rs2_data, 64'h0);
        chk("busy_reset", 64'(b.init_busy), 64'h0);
        chk("done_reset", 64'(b.init_done), 64'h0);
        next(); b.rd_warp = 3; b.rs1_addr = 14;
        @(negedge clk);
        chk("r14_w3_reset", b.rs1_data, 64'h000F_000E_000D_000C);

        next(); wr(2'd1, 4'd3, 4'b0101, 64'hAAAA_BBBB_CCCC_DDDD);
        next(); b.rd_warp = 1; b.rs1_addr = 3;
        @(negedge clk);
        chk("masked_r3_w1", b.rs1_data, 64'h0000_BBBB_0000_DDDD);
        next(); b.rd_warp = 0; b.rs1_addr = 3;
        @(negedge clk);
        chk("r3_w0_untouched", b.rs1_data, 64'h0);

        next(); wr(2'd0, 4'd5, 4'hF, 64'h1234_5678_9ABC_DEF0); b.rs1_addr = 5;
        @(negedge clk);
        chk("bypass_new", b.rs1_data, 64'h1234_5678_9ABC_DEF0);
        chk("nobypass_old", b0.rs1_data, 64'h0);
        next(); b.rs1_addr = 5;
        @(negedge clk);
        chk("nobypass_after", b0.rs1_data, 64'h1234_5678_9ABC_DEF0);

        next(); wr(2'd0, 4'd15, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
        b.sb_set = 1; b.sb_rd = 15; b.rs1_addr = 15; b.rs2_addr = 15;
        @(negedge clk);
        chk("r15_same_cycle", b.rs1_data, 64'h0);
        chk("r15_hazard_set", 64'(b.hazard), 64'h0);
        next(); b.rs1_addr = 15;
        @(negedge clk);
        chk("r15_after", b.rs1_data, 64'h0);
        chk("r15_hazard_after", 64'(b.hazard), 64'h0);

        next(); b.sb_set = 1; b.sb_rd = 7; b.rd_warp = 2;
        @(negedge clk);
        chk("sb_not_yet", 64'(b.hazard), 64'h0);
        next(); b.rd_warp = 2; b.rs1_addr = 7;
        @(negedge clk);
        chk("sb_pending", 64'(b.hazard), 64'h1);
        next(); wr(2'd2, 4'd7, 4'h0, 64'h0); b.sb_set = 1; b.sb_rd = 7; b.rd_warp = 2;
        @(negedge clk);
        chk("sb_query_rd", 64'(b.hazard), 64'h1);
        next(); b.rd_warp = 2; b.rs1_addr = 7;
        @(negedge clk);
        chk("sb_set_wins", 64'(b.hazard), 64'h1);
        next(); wr(2'd2, 4'd7, 4'h0, 64'h0); b.rd_warp = 2; b.rs2_addr = 7;
        next(); b.rd_warp = 2; b.rs2_addr = 7;
        @(negedge clk);
        chk("sb_cleared", 64'(b.hazard), 64'h0);

        next(); wr(2'd3, 4'd14, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
        next(); wr(2'd2, 4'd0, 4'b1010, 64'h1111_2222_3333_4444); b.sb_set = 1; b.sb_rd = 9; b.rd_warp = 1;
        next(); b.rd_warp = 1; b.rs1_addr = 9;
        @(negedge clk);
        chk("dirty_pending", 64'(b.hazard), 64'h1);

        run_sweep(-1, nb, nd, lb, fd);
        chk("sweep_busy_cycles", 64'(nb), 64'd64);
        chk("sweep_done_count", 64'(nd), 64'd1);
        chk("sweep_done_after_busy", 64'(fd), 64'(lb + 1));
        next(); b.rd_warp = 3; b.rs1_addr = 14; b.rs2_addr = 0;
        @(negedge clk);
        chk("sweep_r14_w3", b.rs1_data, 64'h000F_000E_000D_000C);
        next(); b.rd_warp = 1; b.rs1_addr = 9; b.rs2_addr = 3;
        @(negedge clk);
        chk("sweep_pend_cleared", 64'(b.hazard), 64'h0);
        chk("sweep_r3_w1", b.rs2_data, 64'h0);
        next(); b.rs1_addr = 0; b.rs2_addr = 2;
        @(negedge clk);
        chk("sweep_dropped_we", b.rs1_data, 64'h0);
        chk("sweep_dropped_sb", 64'(b.hazard), 64'h0);

        next(); wr(2'd0, 4'd14, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_sweep(20, nb, nd, lb, fd);
        chk("rst_mid_busy_cycles", 64'(nb), 64'd19);
        chk("rst_mid_no_done", 64'(nd), 64'd0);
        next(); b.rs1_addr = 14;
        @(negedge clk);
        chk("rst_mid_r14_w0", b.rs1_data, 64'h0003_0002_0001_0000);

        next();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
